ahb_input_stage_dmam: RTL and testbench
=======================================

// Module: ahb_input_stage_dmam
// PURPOSE
//  Per-master input stage of the DMA bus matrix, upstream of each output-port arbiter.
//  Passes the master's address phase straight through when its output port grants it.
//  Otherwise captures the address phase in a holding register, stalls the master with wait states,
//  and raises req_port until granted. Also returns the granted slave's data-phase ready/response to the master.
// PARAMETERS
//  ADDR_WIDTH     32   address bus width
//  TIMEOUT_CYCLES 255  max PEND cycles before error (only with INPUT_STAGE_TIMEOUT_EN)
// PORTS
//  HCLK        in  1   AHB clock
//  HRESETn     in  1   reset, asynchronous, active-low
//  HSELS       in  1   master-side select
//  HADDRS      in  AW  address
//  HTRANSS     in  2   transfer type
//  HWRITES     in  1   write
//  HSIZES      in  3   size
//  HBURSTS     in  3   burst type
//  HPROTS      in  4   protection
//  HMASTLOCKS  in  1   locked transfer
//  HREADYS     in  1   bus HREADY seen by master
//  HREADYOUTS  out 1   ready returned to master
//  HRESPS      out 1   response returned to master (0 OKAY, 1 ERROR)
//  req_port    out 1   request to output-port arbiter (= sel_op)
//  sel_op/addr_op/trans_op/write_op/size_op/burst_op/prot_op/lock_op  out  address phase to output stage
//  active_op   in  1   this port owns target output address phase this cycle (granted & HREADYM)
//  readyout_op in  1   slave HREADYOUT for this port's data phase
//  resp_op     in  1   slave HRESP for this port's data phase
// BEHAVIOUR
//  Definition: sample = HSELS & HTRANSS[1] & HREADYS (NONSEQ/SEQ only; IDLE/BUSY never captured).
//  FSM states: IDLE, PEND, DATA (+ERR1, ERR2 with macro). PEND and DATA are mutually exclusive.
//  IDLE:
//   - sample & active_op -> DATA
//   - sample & ~active_op -> PEND, latch all address-phase inputs
//   - HREADYOUTS=1, HRESPS=0.
//  PEND:
//   - op outputs come from holding register; sel_op=1.
//   - Held SEQ is issued as NONSEQ.
//   - Held non-SINGLE burst is issued as INCR (3'b001).
//   - HREADYOUTS=0, HRESPS=0.
//   - active_op -> DATA; otherwise stay in PEND.
//  DATA:
//   - HREADYOUTS=readyout_op, HRESPS=resp_op.
//   - ~readyout_op: stay in DATA.
//   - readyout_op: sample&active_op -> DATA; sample&~active_op -> PEND (latch); else -> IDLE.
//  Op outputs in IDLE/DATA: combinational pass-through of master inputs; sel_op=HSELS&HTRANSS[1].
//  Latency:
//   - Zero added cycles when granted.
//   - Each ungranted cycle adds one master wait state.
//  Lock: HMASTLOCKS is captured with the held transfer and driven on lock_op until issued.
//  Capture is enabled only by sample; holding register is never overwritten while in PEND.
//  Reset (async, any state, mid-transfer included):
//   - state=IDLE, holding register=0, HREADYOUTS=1, HRESPS=0, sel_op=0.
//   - Pending transfer is discarded.
// CONFIGURATION
//  INPUT_STAGE_TIMEOUT_EN defined:
//   - Counter starts at 0 on entry to PEND and increments each PEND cycle.
//   - On reaching TIMEOUT_CYCLES without active_op: -> ERR1.
//   - ERR1: HREADYOUTS=0, HRESPS=1.
//   - ERR2: HREADYOUTS=1, HRESPS=1.
//   - Then IDLE; held transfer dropped (sel_op=0 in ERR1/ERR2).
//   - Timeout is suppressed while the held transfer is locked.
//  INPUT_STAGE_TIMEOUT_EN undefined: no counter; PEND waits indefinitely; TIMEOUT_CYCLES unused.
// STRUCTURE
//  Shared package ahb_matrix_pkg:
//   - HTRANS codes IDLE/BUSY/NONSEQ/SEQ.
//   - HBURST codes SINGLE/INCR.
//   - HRESP OKAY/ERROR.
//   - state enum encoding.
//  One sub-module: ahb_input_stage_timeout (counter + expiry flag), instantiated only under the macro.
// TESTING
//  1. Reset: HRESETn=0 mid-PEND -> HREADYOUTS=1, HRESPS=0, sel_op=0; state IDLE after release.
//  2. Granted pass-through: NONSEQ addr 0x4000_0000, active_op=1 -> addr_op same cycle;
//     next cycle HREADYOUTS tracks readyout_op (0,0,1 -> 2 wait states).
//  3. Blocked: SEQ INCR4 addr 0x10, active_op=0 for 3 cycles -> HREADYOUTS=0 for 3 cycles, req_port=1;
//     on grant trans_op=NONSEQ, burst_op=INCR, addr_op=0x10.
//  4. Back-to-back: DATA completes while next NONSEQ is ungranted -> enter PEND, held addr stable
//     despite master input changes.
//  5. Error pass-back: resp_op=1 with readyout_op 0 then 1 -> HRESPS=1 both cycles, HREADYOUTS 0 then 1.
//  6. Timeout (macro on, TIMEOUT_CYCLES=4): no grant -> ERR1 after 4 PEND cycles, then ERR2, IDLE;
//     locked held transfer -> no timeout.

Source files
------------

// File: rtl/ahb_matrix_pkg.sv
// Shared AHB bus-matrix definitions: transfer/burst/response codes, input-stage state codes
// and the captured address-phase control fields.
package ahb_matrix_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PEND = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  typedef struct packed {
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } addr_ctrl_t;

  // A held transfer loses its burst context, so anything but SINGLE restarts as INCR.
  function automatic logic [2:0] issue_burst(input logic [2:0] burst);
    return (burst == HBURST_SINGLE) ? HBURST_SINGLE : HBURST_INCR;
  endfunction

endpackage

// File: rtl/ahb_input_stage_timeout.sv
// PEND-duration counter for the input stage; expired is high during the last allowed
// PEND cycle. Instantiated only when INPUT_STAGE_TIMEOUT_EN is defined.
module ahb_input_stage_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pend,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates so a locked (non-expiring) hold cannot wrap the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (!pend)
      count <= '0;
    else if (count != LAST)
      count <= count + CW'(1);
  end

  assign expired = pend & (count == LAST);

endmodule

// File: rtl/ahb_input_stage_dmam.sv
// Per-master input stage of the DMA bus matrix: pass-through when granted, otherwise hold
// the address phase and stall the master. Optional PEND timeout via INPUT_STAGE_TIMEOUT_EN.
module ahb_input_stage_dmam
  import ahb_matrix_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  req_port,
  output logic                  sel_op,
  output logic [ADDR_WIDTH-1:0] addr_op,
  output logic [1:0]            trans_op,
  output logic                  write_op,
  output logic [2:0]            size_op,
  output logic [2:0]            burst_op,
  output logic [3:0]            prot_op,
  output logic                  lock_op,
  input  logic                  active_op,
  input  logic                  readyout_op,
  input  logic                  resp_op
);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] hold_addr;
  addr_ctrl_t            hold_ctrl;
  logic                  sample;
  logic                  capture;
  logic                  timeout_hit;

  assign sample = HSELS & HTRANSS[1] & HREADYS;

`ifdef INPUT_STAGE_TIMEOUT_EN
  ahb_input_stage_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (HCLK),
    .rst_n  (HRESETn),
    .pend   (state == ST_PEND),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sample) begin
          if (active_op) begin
            state_nxt = ST_DATA;
          end else begin
            state_nxt = ST_PEND;
            capture   = 1'b1;
          end
        end
      end
      ST_PEND: begin
        if (active_op)
          state_nxt = ST_DATA;
        else if (timeout_hit && !hold_ctrl.lock)
          state_nxt = ST_ERR1;
      end
      ST_DATA: begin
        if (readyout_op) begin
          if (sample && active_op) begin
            state_nxt = ST_DATA;
          end else if (sample) begin
            state_nxt = ST_PEND;
            capture   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      hold_addr <= '0;
      hold_ctrl <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        hold_addr <= HADDRS;
        hold_ctrl <= '{write: HWRITES, size: HSIZES, burst: HBURSTS,
                       prot: HPROTS, lock: HMASTLOCKS};
      end
    end
  end

  // sel_op is gated by reset so no request escapes while the stage is held in reset.
  always_comb begin
    sel_op     = HRESETn & HSELS & HTRANSS[1];
    addr_op    = HADDRS;
    trans_op   = HTRANSS;
    write_op   = HWRITES;
    size_op    = HSIZES;
    burst_op   = HBURSTS;
    prot_op    = HPROTS;
    lock_op    = HMASTLOCKS;
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    case (state)
      ST_PEND: begin
        sel_op     = 1'b1;
        addr_op    = hold_addr;
        trans_op   = HTRANS_NONSEQ;
        write_op   = hold_ctrl.write;
        size_op    = hold_ctrl.size;
        burst_op   = issue_burst(hold_ctrl.burst);
        prot_op    = hold_ctrl.prot;
        lock_op    = hold_ctrl.lock;
        HREADYOUTS = 1'b0;
      end
      ST_DATA: begin
        HREADYOUTS = readyout_op;
        HRESPS     = resp_op;
      end
      ST_ERR1: begin
        sel_op     = 1'b0;
        HREADYOUTS = 1'b0;
        HRESPS     = HRESP_ERROR;
      end
      ST_ERR2: begin
        sel_op = 1'b0;
        HRESPS = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  assign req_port = sel_op;

endmodule

// File: tb/tb_ahb_input_stage_dmam.sv
// Self-checking bench for ahb_input_stage_dmam: directed scenarios plus random traffic
// against a transaction-level reference model (timeout paths when INPUT_STAGE_TIMEOUT_EN).
module tb_ahb_input_stage_dmam;
  import ahb_matrix_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;
`ifdef INPUT_STAGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          HCLK, HRESETn, HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [AW-1:0] HADDRS;
  logic [1:0]    HTRANSS;
  logic [2:0]    HSIZES, HBURSTS;
  logic [3:0]    HPROTS;
  logic          HREADYOUTS, HRESPS, req_port, sel_op, write_op, lock_op;
  logic [AW-1:0] addr_op;
  logic [1:0]    trans_op;
  logic [2:0]    size_op, burst_op;
  logic [3:0]    prot_op;
  logic          active_op, readyout_op, resp_op;

  ahb_input_stage_dmam #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .req_port(req_port), .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op),
    .write_op(write_op), .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op),
    .lock_op(lock_op), .active_op(active_op), .readyout_op(readyout_op), .resp_op(resp_op)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: an outstanding held transfer, an outstanding data phase,
  // an error-response phase counter and the number of PEND cycles already spent.
  bit            m_pend, m_data;
  int            m_err, m_wait;
  logic [AW-1:0] h_addr;
  logic          h_write, h_lock;
  logic [2:0]    h_size, h_burst;
  logic [3:0]    h_prot;

  task automatic model_reset();
    m_pend = 0; m_data = 0; m_err = 0; m_wait = 0;
  endtask

  function automatic logic exp_ready();
    if (m_err == 1) return 1'b0;
    if (m_err == 2) return 1'b1;
    if (m_pend)     return 1'b0;
    if (m_data)     return readyout_op;
    return 1'b1;
  endfunction

  task automatic check_outputs();
    logic e_resp;
    e_resp = (m_err != 0) ? 1'b1 : (!m_pend && m_data) ? resp_op : 1'b0;
    chk("ready", HREADYOUTS, exp_ready());
    chk("resp", HRESPS, e_resp);
    if (m_err != 0) begin
      chk("sel_err", sel_op, 0);
      chk("req_err", req_port, 0);
    end else if (m_pend) begin
      chk("sel_pend", sel_op, 1);
      chk("req_pend", req_port, 1);
      chk("addr_pend", addr_op, h_addr);
      chk("trans_pend", trans_op, HTRANS_NONSEQ);
      chk("burst_pend", burst_op, (h_burst == 3'b000) ? 3'b000 : 3'b001);
      chk("write_pend", write_op, h_write);
      chk("size_pend", size_op, h_size);
      chk("prot_pend", prot_op, h_prot);
      chk("lock_pend", lock_op, h_lock);
    end else begin
      chk("sel_pass", sel_op, HRESETn & HSELS & HTRANSS[1]);
      chk("req_pass", req_port, HRESETn & HSELS & HTRANSS[1]);
      chk("addr_pass", addr_op, HADDRS);
      chk("trans_pass", trans_op, HTRANSS);
      chk("burst_pass", burst_op, HBURSTS);
      chk("ctrl_pass", {write_op, size_op, prot_op, lock_op},
          {HWRITES, HSIZES, HPROTS, HMASTLOCKS});
    end
  endtask

  task automatic model_advance();
    bit smp;
    if (!HRESETn) begin model_reset(); return; end
    smp = HSELS & HTRANSS[1] & HREADYS;
    if (m_err == 1) m_err = 2;
    else if (m_err == 2) m_err = 0;
    else if (m_pend) begin
      if (active_op) begin m_pend = 0; m_data = 1; end
      else if (TO_EN && !h_lock && m_wait + 1 >= TO) begin m_pend = 0; m_err = 1; end
      else m_wait++;
    end else if (!m_data || readyout_op) begin
      m_data = smp && active_op;
      if (smp && !active_op) begin
        m_pend = 1; m_wait = 0;
        h_addr = HADDRS; h_write = HWRITES; h_size = HSIZES;
        h_burst = HBURSTS; h_prot = HPROTS; h_lock = HMASTLOCKS;
      end
    end
  endtask

  task automatic settle_check();
    #3;
    check_outputs();
  endtask

  task automatic advance();
    model_advance();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    HSELS = 0; HADDRS = '0; HTRANSS = HTRANS_IDLE; HWRITES = 0; HSIZES = 3'd2;
    HBURSTS = HBURST_SINGLE; HPROTS = 4'h3; HMASTLOCKS = 0; HREADYS = 1;
    active_op = 0; readyout_op = 1; resp_op = 0;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [1:0] t, input logic [2:0] b,
                       input logic lk, input logic act);
    HSELS = 1; HADDRS = a; HTRANSS = t; HBURSTS = b; HMASTLOCKS = lk;
    HREADYS = 1; active_op = act;
  endtask

  task automatic rand_inputs();
    HSELS = ($urandom_range(0, 9) != 0);
    HTRANSS = 2'($urandom); HADDRS = $urandom; HWRITES = 1'($urandom);
    HSIZES = 3'($urandom); HBURSTS = 3'($urandom); HPROTS = 4'($urandom);
    HMASTLOCKS = ($urandom_range(0, 7) == 0);
    active_op = 1'($urandom); readyout_op = ($urandom_range(0, 3) != 0);
    resp_op = ($urandom_range(0, 4) == 0);
    HREADYS = ($urandom_range(0, 15) == 0) ? 1'($urandom) : exp_ready();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    HRESETn = 0;
    model_reset();
    @(posedge HCLK); #1;
    settle_check(); advance();
    HRESETn = 1;
    settle_check();
    chk("rst_ready", HREADYOUTS, 1);
    advance();

    // Granted pass-through, then three data-phase cycles with two wait states.
    issue(32'h4000_0000, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1);
    settle_check();
    chk("t2_addr", addr_op, 32'h4000_0000);
    chk("t2_sel", sel_op, 1);
    advance();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      readyout_op = (i == 2);
      HREADYS = readyout_op;
      settle_check();
      chk("t2_wait", HREADYOUTS, (i == 2));
      advance();
    end

    // Blocked SEQ INCR4 held for three ungranted cycles, then issued on grant.
    issue(32'h10, HTRANS_SEQ, 3'b011, 0, 0);
    settle_check(); advance();
    for (int i = 0; i < 3; i++) begin
      HADDRS = $urandom; HTRANSS = HTRANS_NONSEQ; HREADYS = 0;
      settle_check();
      chk("t3_stall", HREADYOUTS, 0);
      chk("t3_req", req_port, 1);
      advance();
    end
    active_op = 1;
    settle_check();
    chk("t3_trans", trans_op, HTRANS_NONSEQ);
    chk("t3_burst", burst_op, HBURST_INCR);
    chk("t3_addr", addr_op, 32'h10);
    advance();

    // Error pass-back over two cycles; the next NONSEQ arrives ungranted as it ends.
    HSELS = 0; HTRANSS = HTRANS_IDLE; HREADYS = 0; active_op = 0;
    readyout_op = 0; resp_op = 1;
    settle_check();
    chk("t5_resp0", HRESPS, 1);
    chk("t5_ready0", HREADYOUTS, 0);
    advance();
    readyout_op = 1;
    issue(32'h2000, HTRANS_NONSEQ, HBURST_INCR, 0, 0);
    settle_check();
    chk("t5_resp1", HRESPS, 1);
    chk("t5_ready1", HREADYOUTS, 1);
    advance();
    resp_op = 0;
    for (int i = 0; i < 2; i++) begin
      HADDRS = 32'hDEAD_BEEF + i; HREADYS = 1;
      settle_check();
      chk("t4_held", addr_op, 32'h2000);
      advance();
    end

    // Asynchronous reset while a transfer is held.
    HRESETn = 0;
    #1;
    chk("t1_sel", sel_op, 0);
    chk("t1_ready", HREADYOUTS, 1);
    chk("t1_resp", HRESPS, 0);
    model_reset();
    settle_check(); advance();
    idle_inputs();
    HRESETn = 1;
    settle_check();
    chk("t1_idle", HREADYOUTS, 1);
    advance();

`ifdef INPUT_STAGE_TIMEOUT_EN
    issue(32'h300, HTRANS_NONSEQ, HBURST_SINGLE, 0, 0);
    settle_check(); advance();
    HREADYS = 0;
    for (int i = 0; i < 4; i++) begin
      settle_check();
      chk("t6_pend", HREADYOUTS, 0);
      advance();
    end
    settle_check();
    chk("t6_err1", {HREADYOUTS, HRESPS, sel_op}, 3'b010);
    advance();
    settle_check();
    chk("t6_err2", {HREADYOUTS, HRESPS, sel_op}, 3'b110);
    advance();
    idle_inputs();
    settle_check();
    chk("t6_idle", {HREADYOUTS, HRESPS}, 2'b10);
    advance();
    issue(32'h400, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0);
    settle_check(); advance();
    HREADYS = 0;
    for (int i = 0; i < 10; i++) begin
      settle_check();
      chk("t6_locked", {HREADYOUTS, HRESPS, lock_op}, 3'b001);
      advance();
    end
    active_op = 1;
    settle_check(); advance();
    idle_inputs();
    settle_check(); advance();
`endif

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      settle_check();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
